instruction_fetch_stage: RTL

//  Requester side of the instruction-memory interface: owns the PC, drives the fetch address
//  to the combinational instruction memory and captures the returned word into the IF/ID

---
 rtl/instruction_fetch_stage.sv | 91 +++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory and fills IF/ID.
// Optional performance counters are enabled with IF_PERF_CNT_EN.
module instruction_fetch_stage #(
    parameter int                PC_W      = 32,
    parameter int                PC_INC    = 1,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    logic [PC_W-1:0] pc;
    if_id_t          if_id;
    logic            advance;

    // A taken branch overrides stall; the wrong-path word is dropped.
    assign advance   = !branch_taken && !stall;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id.pc    <= '0;
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else begin
            if (branch_taken)
                pc <= branch_target;
            else if (!stall)
                pc <= pc + PC_W'(PC_INC);

            // Flush wins over stall for IF/ID only; the PC still obeys stall.
            if (branch_taken || flush) begin
                if_id.instr <= NOP_INSTR;
                if_id.valid <= 1'b0;
            end else if (!stall) begin
                if_id.pc    <= pc;
                if_id.instr <= imem_instr;
                if_id.valid <= 1'b1;
            end
        end
    end

    assign if_id_pc    = if_id.pc;
    assign if_id_instr = if_id.instr;
    assign if_id_valid = if_id.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (advance)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && !branch_taken)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
    assign fetch_count    = '0;
    assign stall_count    = '0;
`endif

endmodule
